// File: rtl/soma_pkg.sv
// Shared soma/axon constants: default widths and slot count used by the
// soma and by the axon delay line feeding it.
package soma_pkg;

  localparam int SOMA_SPIKE_W   = 16;
  localparam int SOMA_WEIGHT_W  = 16;
  localparam int SOMA_NUM_SLOTS = 4;
  localparam int DROP_CNT_W     = 8;

endpackage

// File: rtl/delay_slot.sv
// One in-flight spike: occupied flag plus a countdown of cycles to delivery.
// expire_o marks the delivery cycle; expire_next_o marks the cycle before it.
module delay_slot #(
  parameter int SPIKE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               kill_i,
  input  logic               load_i,
  input  logic [SPIKE_W-1:0] load_val_i,
  output logic               occupied_o,
  output logic               expire_o,
  output logic               expire_next_o
);

  logic               occ_q, occ_d;
  logic [SPIKE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    occ_d = occ_q;
    cnt_d = cnt_q;
    if (kill_i) begin
      occ_d = 1'b0;
      cnt_d = '0;
    end else if (load_i) begin
      occ_d = 1'b1;
      cnt_d = load_val_i;
    end else if (occ_q) begin
      // A count of 1 is the delivery cycle; the slot frees on the next edge.
      if (cnt_q == SPIKE_W'(1)) begin
        occ_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q - SPIKE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  assign occupied_o    = occ_q;
  assign expire_o      = occ_q && (cnt_q == SPIKE_W'(1));
  assign expire_next_o = occ_q && (cnt_q == SPIKE_W'(2));

endmodule

// File: rtl/axon_delay_line.sv
// Axon delay line: holds up to NUM_SLOTS spikes, each delivered D cycles after
// arrival as weight x (number of coincident expiries), saturated.
module axon_delay_line
  import soma_pkg::*;
#(
  parameter int NUM_SLOTS = SOMA_NUM_SLOTS,
  parameter int SPIKE_W   = SOMA_SPIKE_W,
  parameter int WEIGHT_W  = SOMA_WEIGHT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             kill,
  input  logic [SPIKE_W-1:0]               spike_in,
  input  logic                             cfg_we,
  input  logic [WEIGHT_W-1:0]              cfg_weight,
  output logic [WEIGHT_W-1:0]              weight_out,
  output logic                             weight_valid,
  output logic                             drop_pulse,
  output logic [DROP_CNT_W-1:0]            drop_count,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   active_cnt
);

  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);
  localparam int PROD_W = WEIGHT_W + CNT_W;

  logic [NUM_SLOTS-1:0]  occupied, expire, expire_next, load;
  logic                  spike_vld, slot_free, accept, drop;
  logic [CNT_W-1:0]      deliver_k, active_d;
  logic [PROD_W-1:0]     product;
  logic [WEIGHT_W-1:0]   weight_out_d;

  logic [WEIGHT_W-1:0]   weight_q, weight_out_q;
  logic                  weight_valid_q, drop_pulse_q;
  logic [DROP_CNT_W-1:0] drop_count_q;
  logic [CNT_W-1:0]      active_cnt_q;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      delay_slot #(.SPIKE_W(SPIKE_W)) u_slot (
        .clk           (clk),
        .rst           (rst),
        .kill_i        (kill),
        .load_i        (load[gi]),
        .load_val_i    (spike_in),
        .occupied_o    (occupied[gi]),
        .expire_o      (expire[gi]),
        .expire_next_o (expire_next[gi])
      );
    end
  endgenerate

  // Lowest-index free slot wins; a slot in its expiry cycle still counts as busy.
  always_comb begin
    load      = '0;
    slot_free = 1'b0;
    spike_vld = (spike_in != '0) && !kill;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!occupied[i] && !slot_free) begin
        slot_free = 1'b1;
        load[i]   = spike_vld;
      end
    end
    accept = spike_vld && slot_free;
    drop   = spike_vld && !slot_free;
  end

  // Deliveries registered now show next cycle: slots at count 2, plus a D=1 arrival.
  always_comb begin
    deliver_k = CNT_W'(accept && (spike_in == SPIKE_W'(1)));
    active_d  = CNT_W'(accept);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      deliver_k = deliver_k + CNT_W'(expire_next[i]);
      active_d  = active_d + CNT_W'(occupied[i] && !expire[i]);
    end
  end

  always_comb begin
    product      = {{CNT_W{1'b0}}, weight_q} * {{WEIGHT_W{1'b0}}, deliver_k};
    weight_out_d = '0;
    if (deliver_k != '0) begin
      weight_out_d = (product[PROD_W-1:WEIGHT_W] != '0) ? '1 : product[WEIGHT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q       <= '0;
      weight_out_q   <= '0;
      weight_valid_q <= 1'b0;
      drop_pulse_q   <= 1'b0;
      drop_count_q   <= '0;
      active_cnt_q   <= '0;
    end else begin
      if (cfg_we) begin
        weight_q <= cfg_weight;
      end
      if (kill) begin
        weight_out_q   <= '0;
        weight_valid_q <= 1'b0;
        drop_pulse_q   <= 1'b0;
        active_cnt_q   <= '0;
      end else begin
        weight_out_q   <= weight_out_d;
        weight_valid_q <= (deliver_k != '0);
        drop_pulse_q   <= drop;
        active_cnt_q   <= active_d;
        if (drop && (drop_count_q != '1)) begin
          drop_count_q <= drop_count_q + DROP_CNT_W'(1);
        end
      end
    end
  end

  assign weight_out   = weight_out_q;
  assign weight_valid = weight_valid_q;
  assign drop_pulse   = drop_pulse_q;
  assign drop_count   = drop_count_q;
  assign active_cnt   = active_cnt_q;

endmodule

// File: doc/axon_delay_line.md
AXON_DELAY_LINE -- requirements
Module: axon_delay_line

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, giving the number of concurrent in-flight spikes (range 2..8).
REQ-002 SHALL have parameter SPIKE_W, default 16, giving the width of the spike delay word.
REQ-003 SHALL have parameter WEIGHT_W, default 16, giving the width of the synaptic weight.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port kill, input, 1 bit: synchronous flush of all in-flight spikes.
REQ-007 SHALL have port spike_in, input, SPIKE_W bits: soma spike_out word, where nonzero is a spike with delay D = spike_in in cycles and zero is no spike.
REQ-008 SHALL have port cfg_we, input, 1 bit: weight register write strobe.
REQ-009 SHALL have port cfg_weight, input, WEIGHT_W bits: new synaptic weight.
REQ-010 SHALL have port weight_out, output, WEIGHT_W bits: weight delivered to the downstream soma weight input.
REQ-011 SHALL have port weight_valid, output, 1 bit: downstream soma en, high for exactly one cycle per delivery.
REQ-012 SHALL have port drop_pulse, output, 1 bit: one-cycle pulse when a spike is rejected because all slots are busy.
REQ-013 SHALL have port drop_count, output, 8 bits: saturating count of rejected spikes.
REQ-014 SHALL have port active_cnt, output, clog2(NUM_SLOTS+1) bits: number of occupied slots.

Function
REQ-015 SHALL sample spike_in every cycle; a nonzero value accepted in cycle t SHALL produce its delivery with weight_valid high in cycle t+D, so D=1 delivers in the next cycle.
REQ-016 SHALL allocate an accepted spike to the lowest-index unoccupied slot, loading its remaining count with D.
REQ-017 SHALL decrement each occupied slot's count by 1 per cycle; a slot whose count is 1 SHALL expire, contribute to delivery that cycle, and become unoccupied the next cycle.
REQ-018 SHALL treat an expiring slot as occupied for allocation in its expiry cycle, so there is no same-cycle reuse.
REQ-019 SHALL, when all slots are occupied and spike_in is nonzero, discard the spike, pulse drop_pulse in the next cycle, and increment drop_count, holding it at 8'hFF.
REQ-020 SHALL, when k slots expire in the same cycle, register weight_out = weight x k, saturated to all-ones of WEIGHT_W, and assert weight_valid once.
REQ-021 SHALL hold weight_out at 0 whenever weight_valid is low.
REQ-022 SHALL have cfg_we load the weight register at the clock edge; deliveries registered in later cycles use the new value, including spikes already in flight.
REQ-023 SHALL have kill clear all slots, weight_valid and active_cnt in the next cycle; a spike arriving in the same cycle as kill SHALL be discarded and not counted as a drop.
REQ-024 SHALL leave drop_count and the weight register unchanged on kill.
REQ-025 SHALL register active_cnt each cycle to reflect slot occupancy after that cycle's allocation and expiry.
REQ-026 SHALL have all outputs registered, with no combinational path from any input to any output.

Reset
REQ-027 SHALL, on rst, clear all slots, weight_out, weight_valid, drop_pulse, drop_count, active_cnt and the weight register to 0.
REQ-028 SHALL give rst priority over kill, cfg_we and spike_in, discarding in-flight spikes mid-operation with no delivery after reset.

Structure
REQ-029 SHALL take SPIKE_W, WEIGHT_W and the default NUM_SLOTS from shared package soma_pkg, which the soma also uses.
REQ-030 SHALL implement each slot as sub-module delay_slot (occupied flag, countdown, load, kill, and expire output), instantiated NUM_SLOTS times.
REQ-031 SHALL keep allocation priority, the expiry counter and saturating multiply in the top level.

Verification
REQ-032 SHALL cover: weight=5, spike_in=3 at cycle 10 -> weight_valid=1, weight_out=5 only at cycle 13.
REQ-033 SHALL cover: weight=7, spikes D=4 at t0 and D=3 at t0+1 -> single delivery weight_out=14 at t0+4.
REQ-034 SHALL cover: NUM_SLOTS=4, five spikes D=20 on consecutive cycles -> active_cnt=4, one drop_pulse, drop_count=1, four deliveries.
REQ-035 SHALL cover: weight=16'hC000 with two coincident expiries -> weight_out=16'hFFFF.
REQ-036 SHALL cover: three spikes in flight, kill together with spike_in=2 -> active_cnt=0 next cycle, no delivery, drop_count unchanged.
REQ-037 SHALL cover: spike D=5, cfg_we to weight 9 at +2, rst asserted at +3 -> no weight_valid ever, all outputs 0.
